// File: rtl/au_accum.sv
// Registered accumulator closed around a combinational adder-subtractor,
// with valid/ready on both sides, sticky signed overflow and a saturating sample count.

module au_addsub #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] s_o
);
    // Only the carries into bits 1..WIDTH-1 are needed; the carry-out is dropped.
    localparam int N   = WIDTH - 1;
    localparam int LVL = $clog2(N);

    logic [WIDTH-1:0] bx_s;
    logic [WIDTH-1:0] p_s;
    logic [N-1:0]     g_s;
    logic [N-1:0]     pl_s;
    logic [N-1:0]     grp_s;

    assign bx_s = b_i ^ {WIDTH{sub_i}};
    assign p_s  = a_i ^ bx_s;
    assign pl_s = p_s[N-1:0];

    // Bit-level generate, with the subtract carry-in folded into bit 0.
    always_comb begin
        g_s    = a_i[N-1:0] & bx_s[N-1:0];
        g_s[0] = (a_i[0] & bx_s[0]) | (p_s[0] & sub_i);
    end

    generate
        if (ARCH == 1) begin : g_ks
            // Kogge-Stone prefix tree: every position combines at each distance.
            always_comb begin : p_ks
                logic [N-1:0] gv, pv, gn, pn;
                int d;
                int j;
                gv = g_s;
                pv = pl_s;
                gn = g_s;
                pn = pl_s;
                d  = 32'sd1;
                j  = 32'sd0;
                for (int k = 0; k < LVL; k++) begin
                    for (int i = 0; i < N; i++) begin
                        j = (i >= d) ? (i - d) : i;
                        if (i >= d) begin
                            gn[i] = gv[i] | (pv[i] & gv[j]);
                            pn[i] = pv[i] & pv[j];
                        end else begin
                            gn[i] = gv[i];
                            pn[i] = pv[i];
                        end
                    end
                    gv = gn;
                    pv = pn;
                    d  = d * 32'sd2;
                end
                grp_s = gv;
            end
        end else if (ARCH == 2) begin : g_sk
            // Sklansky divide-and-conquer: upper half of each block takes the lower half's group.
            always_comb begin : p_sk
                logic [N-1:0] gv, pv, gn, pn;
                int d;
                int j;
                gv = g_s;
                pv = pl_s;
                gn = g_s;
                pn = pl_s;
                d  = 32'sd1;
                j  = 32'sd0;
                for (int k = 0; k < LVL; k++) begin
                    for (int i = 0; i < N; i++) begin
                        j = i - (i % d) - 32'sd1;
                        if (((i / d) % 32'sd2) == 32'sd1) begin
                            gn[i] = gv[i] | (pv[i] & gv[j]);
                            pn[i] = pv[i] & pv[j];
                        end else begin
                            gn[i] = gv[i];
                            pn[i] = pv[i];
                        end
                    end
                    gv = gn;
                    pv = pn;
                    d  = d * 32'sd2;
                end
                grp_s = gv;
            end
        end else begin : g_rc
            // Ripple carry chain.
            always_comb begin : p_rc
                logic [N-1:0] gv;
                gv    = g_s;
                gv[0] = g_s[0];
                for (int i = 1; i < N; i++) begin
                    gv[i] = g_s[i] | (pl_s[i] & gv[i-1]);
                end
                grp_s = gv;
            end
        end
    endgenerate

    assign s_o = p_s ^ {grp_s, sub_i};

endmodule

module au_accum #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             add_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam int               MSB     = WIDTH - 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             vld_q, vld_d;
    logic             accept_s;
    logic             v_s;

    au_addsub #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_addsub (
        .a_i   (acc_q),
        .b_i   (din),
        .sub_i (add_sub),
        .s_o   (sum_s)
    );

    // A full output stage still accepts when it is being drained this cycle.
    assign in_ready = ~clr & (~vld_q | out_ready);
    assign accept_s = in_valid & in_ready;

    // Signed overflow of the current operation, from operand and result signs.
    always_comb begin
        v_s = 1'b0;
        if (add_sub) begin
            v_s = (acc_q[MSB] != din[MSB]) & (sum_s[MSB] != acc_q[MSB]);
        end else begin
            v_s = (acc_q[MSB] == din[MSB]) & (sum_s[MSB] != acc_q[MSB]);
        end
    end

    // Next state: clear wins, then accept, then output consumption.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        vld_d = vld_q;
        if (clr) begin
            acc_d = {WIDTH{1'b0}};
            cnt_d = {CNT_W{1'b0}};
            ovf_d = 1'b0;
            vld_d = 1'b0;
        end else if (accept_s) begin
            acc_d = sum_s;
            ovf_d = ovf_q | v_s;
            vld_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1'b1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (vld_q & out_ready) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {WIDTH{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign acc       = acc_q;
    assign cnt       = cnt_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_au_accum.sv
// Bench for au_accum: three instances (one per carry architecture, one with a 2-bit counter)
// checked every cycle against an integer model, plus directed literal scenarios.

module tb_au_accum;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       add_sub = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy_a, rdy_b, rdy_c;
    logic       vld_a, vld_b, vld_c;
    logic [7:0] acc_a, acc_b, acc_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_acc = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_vld = 1'b0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    au_accum #(.WIDTH(8), .ARCH(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a),
        .din(din), .add_sub(add_sub), .out_valid(vld_a), .out_ready(out_ready),
        .acc(acc_a), .ovf(ovf_a), .cnt(cnt_a));
    au_accum #(.WIDTH(8), .ARCH(1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_b),
        .din(din), .add_sub(add_sub), .out_valid(vld_b), .out_ready(out_ready),
        .acc(acc_b), .ovf(ovf_b), .cnt(cnt_b));
    au_accum #(.WIDTH(8), .ARCH(2), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_c),
        .din(din), .add_sub(add_sub), .out_valid(vld_c), .out_ready(out_ready),
        .acc(acc_c), .ovf(ovf_c), .cnt(cnt_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int arith(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return sub ? (sa - sb) : (sa + sb);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Model: plain integer arithmetic, signed range test for overflow.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= 8'h00; m_ovf <= 1'b0; m_vld <= 1'b0; m_cnt <= 0;
        end else if (clr) begin
            m_acc <= 8'h00; m_ovf <= 1'b0; m_vld <= 1'b0; m_cnt <= 0;
        end else if (in_valid && (!m_vld || out_ready)) begin
            m_acc <= 8'(arith(m_acc, din, add_sub));
            m_ovf <= m_ovf | (arith(m_acc, din, add_sub) > 127) | (arith(m_acc, din, add_sub) < -128);
            m_vld <= 1'b1;
            m_cnt <= m_cnt + 1;
        end else if (m_vld && out_ready) begin
            m_vld <= 1'b0;
        end
    end

    // Per-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = !clr && (!m_vld || out_ready);
        chk("acc_a", acc_a, m_acc);  chk("acc_b", acc_b, m_acc);  chk("acc_c", acc_c, m_acc);
        chk("ovf_a", ovf_a, m_ovf);  chk("ovf_b", ovf_b, m_ovf);  chk("ovf_c", ovf_c, m_ovf);
        chk("vld_a", vld_a, m_vld);  chk("vld_b", vld_b, m_vld);  chk("vld_c", vld_c, m_vld);
        chk("rdy_a", rdy_a, exp_rdy); chk("rdy_b", rdy_b, exp_rdy); chk("rdy_c", rdy_c, exp_rdy);
        chk("cnt_a", cnt_a, sat(m_cnt, 255));
        chk("cnt_b", cnt_b, sat(m_cnt, 3));
        chk("cnt_c", cnt_c, sat(m_cnt, 255));
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic op,
                         input logic ordy, input logic c);
        in_valid = v; din = d; add_sub = op; out_ready = ordy; clr = c;
        @(posedge clk); #2;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] a, input logic o,
                         input int c, input logic v);
        chk({tag, "_acc"}, acc_a, a);
        chk({tag, "_ovf"}, ovf_a, o);
        chk({tag, "_cnt"}, cnt_a, c);
        chk({tag, "_vld"}, vld_a, v);
    endtask

    initial begin
        int exp5 [5];
        exp5 = '{1, 2, 3, 3, 3};
        #3;
        chk_a("in_reset", 8'h00, 1'b0, 0, 1'b0);
        #20 rst_n = 1'b1;
        @(posedge clk); #2;
        chk_a("post_reset", 8'h00, 1'b0, 0, 1'b0);
        chk("post_reset_rdy", rdy_a, 1'b1);

        // Basic stream 3, 5, -(-2)
        drive(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);  chk_a("t1_0", 8'd3, 1'b0, 1, 1'b1);
        drive(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);  chk_a("t1_1", 8'd8, 1'b0, 2, 1'b1);
        drive(1'b1, 8'hFE, 1'b1, 1'b1, 1'b0); chk_a("t1_2", 8'd10, 1'b0, 3, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); chk_a("t1_drain", 8'd10, 1'b0, 3, 1'b0);

        // Signed overflow at 0x7F and stickiness
        drive(1'b1, 8'h75, 1'b0, 1'b1, 1'b0); chk_a("t2_7f", 8'h7F, 1'b0, 4, 1'b1);
        drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0); chk_a("t2_80", 8'h80, 1'b1, 5, 1'b1);
        drive(1'b1, 8'h01, 1'b1, 1'b1, 1'b0); chk_a("t2_back", 8'h7F, 1'b1, 6, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); chk_a("t2_drain", 8'h7F, 1'b1, 6, 1'b0);

        // Backpressure: hold for 5 cycles, then accept on release
        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);  chk_a("t3_acc", 8'h84, 1'b1, 7, 1'b1);
        in_valid = 1'b1; din = 8'd9; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_hold_rdy", rdy_a, 1'b0);
            @(posedge clk); #2;
            chk_a("t3_hold", 8'h84, 1'b1, 7, 1'b1);
        end
        out_ready = 1'b1;
        #1 chk("t3_release_rdy", rdy_a, 1'b1);
        @(posedge clk); #2;
        chk_a("t3_release", 8'h8D, 1'b1, 8, 1'b1);

        // Clear with a pending output and a valid input
        in_valid = 1'b1; din = 8'h11; out_ready = 1'b0; clr = 1'b1;
        #1 chk("t4_rdy", rdy_a, 1'b0);
        @(posedge clk); #2;
        chk_a("t4_clr", 8'h00, 1'b0, 0, 1'b0);

        // Counter saturation on the 2-bit instance
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
            chk("t5_cnt_b", cnt_b, exp5[k]);
            chk("t5_cnt_a", cnt_a, k + 1);
        end

        // Asynchronous reset between edges
        drive(1'b1, 8'd7, 1'b0, 1'b1, 1'b0); chk_a("t6_pre", 8'd12, 1'b0, 6, 1'b1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_a("t6_async", 8'h00, 1'b0, 0, 1'b0);
        chk("t6_cnt_b", cnt_b, 2'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        drive(1'b1, 8'h2A, 1'b0, 1'b1, 1'b0); chk_a("t6_first", 8'h2A, 1'b0, 1, 1'b1);

        // Randomized traffic
        for (int it = 0; it < 3000; it++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            add_sub   = 1'($urandom);
            clr       = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 4))
                0:       din = 8'h7F;
                1:       din = 8'h80;
                2:       din = 8'hFF;
                default: din = 8'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(posedge clk); #2;
        end

        in_valid = 1'b0; clr = 1'b0;
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/au_accum.md
Name: au_accum

Overview:
- Registered accumulator that sits directly downstream of the team's combinational adder-subtractor and closes the loop around it.
- The accumulator register drives operand a; the input word drives operand b. The sum or difference s is captured back into the accumulator on each accepted input.
- Adds valid/ready handshakes on both sides, a sticky signed-overflow flag and a saturating sample counter. Intended for running sums and differences in datapath pipelines.

Parameters:
- WIDTH, 8: word length of accumulator and input (>= 2).
- ARCH, 0: prefix-carry architecture (0 to 2), passed unchanged to the internal adder-subtractor instance.
- CNT_W, 8: width of the accepted-sample counter (>= 1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of accumulator, flag and counter.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word.
- din  input  WIDTH  operand word, two's complement.
- add_sub  input  1  operation for this word; 0: acc+din, 1: acc-din.
- out_valid  output  1  acc, ovf and cnt hold an update not yet consumed.
- out_ready  input  1  downstream consumes the output.
- acc  output  WIDTH  accumulator value; wraps modulo 2^WIDTH.
- ovf  output  1  sticky signed overflow.
- cnt  output  CNT_W  number of accepted words since reset or clr; saturates.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - acc=0, ovf=0, cnt=0, out_valid=0.
  - in_ready evaluates to 1 once reset is released.
  - Reset mid-stream discards any pending output.
- Accept condition: accept = in_valid & in_ready & ~clr.
- in_ready = ~clr & (~out_valid | out_ready). Combinational, so a full one-deep output stage with out_ready=1 still accepts every cycle.
- Arithmetic:
  - s = acc + din when add_sub=0; s = acc - din when add_sub=1.
  - Computed by the internal adder-subtractor instance with a=acc, b=din.
  - Result is WIDTH bits; the carry-out is discarded.
- On accept, at the next edge:
  - acc <= s.
  - cnt <= cnt+1, saturating at 2^CNT_W-1 and holding there.
  - ovf <= ovf | v. For add, v = (acc[MSB]==din[MSB]) & (s[MSB]!=acc[MSB]). For subtract, v = (acc[MSB]!=din[MSB]) & (s[MSB]!=acc[MSB]).
  - out_valid <= 1.
- Latency: one cycle from accept to the updated acc with out_valid=1. Throughput is one word per cycle while out_ready=1.
- Output handshake:
  - out_valid clears at an edge with out_valid & out_ready and no accept.
  - With out_valid & out_ready & accept in the same cycle, out_valid stays 1 and acc takes the new value.
  - While out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0.
- clr=1 at an edge:
  - acc=0, ovf=0, cnt=0, out_valid=0.
  - clr has priority over a simultaneous accept; the input is not taken because in_ready=0.
  - A pending output is dropped regardless of out_ready.
- Wrap-around: acc wraps modulo 2^WIDTH. After overflow, ovf stays 1 until clr or reset, and accumulation continues.
- Outputs acc, ovf and cnt are always readable. out_valid only marks a fresh update.

Test Plan:
1. Reset, then stream din=3,5,-2 with add_sub=0,0,1 and out_ready=1 -> acc sequence 3,8,10; cnt=3; ovf=0; out_valid high one cycle after each accept.
2. acc=0x7F, then din=0x01 add -> acc=0x80, ovf=1; then din=0x01 subtract -> acc=0x7F, ovf stays 1.
3. Hold out_ready=0 after one accept with in_valid=1 -> in_ready=0; acc, ovf and cnt stable for 5 cycles; raise out_ready -> next word is accepted in that same cycle.
4. clr=1 together with in_valid=1 and a pending output -> next cycle acc=0, cnt=0, ovf=0, out_valid=0; input not consumed.
5. CNT_W=2, accept 5 words -> cnt sequence 1,2,3,3,3.
6. Assert rst_n=0 asynchronously mid-stream, between edges -> outputs zero immediately; after release, the first accept yields acc=din.
